// File: rtl/wb_axil_bridge.sv
// Wishbone B4 classic slave to AXI4-Lite master bridge: one Wishbone cycle becomes one AXI-Lite transaction.
// Optional response watchdog enabled by defining WB_AXIL_TIMEOUT_EN.
module wb_axil_bridge #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n_i,
    input  logic [ADDR_W-1:0] wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    input  logic [3:0]        wb_sel_i,
    input  logic              wb_we_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    output logic              wb_err_o,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [31:0]       m_axi_wdata,
    output logic [3:0]        m_axi_wstrb,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [31:0]       m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WADDR,
        S_WRESP,
        S_RADDR,
        S_RRESP,
        S_DONE
    } state_t;

    state_t      r_state;
    logic        r_aw_done;
    logic        r_w_done;
    logic [1:0]  r_resp;
    logic        w_aw_fin;
    logic        w_w_fin;
    logic        w_timeout;
    logic        w_unused_bits;

    // AXI addresses are word aligned; the byte offset is carried by the strobes.
    assign w_unused_bits = &{1'b0, wb_adr_i[1:0]};

    assign w_aw_fin = r_aw_done | (m_axi_awvalid & m_axi_awready);
    assign w_w_fin  = r_w_done  | (m_axi_wvalid  & m_axi_wready);

`ifdef WB_AXIL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_to_cnt;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_to_cnt <= '0;
        end else if ((r_state == S_WRESP) || (r_state == S_RRESP)) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end else begin
            r_to_cnt <= '0;
        end
    end

    assign w_timeout = (r_to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
    assign w_timeout        = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_state       <= S_IDLE;
            r_aw_done     <= 1'b0;
            r_w_done      <= 1'b0;
            r_resp        <= 2'b00;
            wb_dat_o      <= '0;
            wb_ack_o      <= 1'b0;
            wb_err_o      <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wstrb   <= '0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
        end else begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // The ack/err cycle still sees the old strobe, so it must not start a new cycle.
                    if (wb_cyc_i && wb_stb_i && !wb_ack_o && !wb_err_o) begin
                        if (wb_we_i) begin
                            m_axi_awaddr  <= {wb_adr_i[ADDR_W-1:2], 2'b00};
                            m_axi_wdata   <= wb_dat_i;
                            m_axi_wstrb   <= wb_sel_i;
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            r_aw_done     <= 1'b0;
                            r_w_done      <= 1'b0;
                            r_state       <= S_WADDR;
                        end else begin
                            m_axi_araddr  <= {wb_adr_i[ADDR_W-1:2], 2'b00};
                            m_axi_arvalid <= 1'b1;
                            r_state       <= S_RADDR;
                        end
                    end
                end
                S_WADDR: begin
                    if (m_axi_awready) begin
                        m_axi_awvalid <= 1'b0;
                    end
                    if (m_axi_wready) begin
                        m_axi_wvalid <= 1'b0;
                    end
                    r_aw_done <= w_aw_fin;
                    r_w_done  <= w_w_fin;
                    if (w_aw_fin && w_w_fin) begin
                        m_axi_bready <= 1'b1;
                        r_state      <= S_WRESP;
                    end
                end
                S_WRESP: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        r_resp       <= m_axi_bresp;
                        r_state      <= S_DONE;
                    end else if (w_timeout) begin
                        m_axi_bready <= 1'b0;
                        r_resp       <= 2'b10;
                        r_state      <= S_DONE;
                    end
                end
                S_RADDR: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        r_state       <= S_RRESP;
                    end
                end
                S_RRESP: begin
                    if (m_axi_rvalid) begin
                        wb_dat_o     <= m_axi_rdata;
                        m_axi_rready <= 1'b0;
                        r_resp       <= m_axi_rresp;
                        r_state      <= S_DONE;
                    end else if (w_timeout) begin
                        m_axi_rready <= 1'b0;
                        r_resp       <= 2'b10;
                        r_state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    // An aborted master gets no completion pulse.
                    wb_ack_o <= wb_cyc_i && !r_resp[1];
                    wb_err_o <= wb_cyc_i && r_resp[1];
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_axil_bridge.sv
// Directed bench for wb_axil_bridge: table of single transactions plus reset, abort and watchdog sequences.
// Define WB_AXIL_TIMEOUT_EN for both files to exercise the watchdog build.
module tb_wb_axil_bridge;

    localparam int ADDR_W = 32;
    localparam int TO_CYC = 16;
    localparam int NVEC   = 11;

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] wb_adr_i;
    logic [31:0]       wb_dat_i;
    logic [3:0]        wb_sel_i;
    logic              wb_we_i;
    logic              wb_cyc_i;
    logic              wb_stb_i;
    logic [31:0]       wb_dat_o;
    logic              wb_ack_o;
    logic              wb_err_o;
    logic [ADDR_W-1:0] m_axi_awaddr;
    logic              m_axi_awvalid;
    logic              m_axi_awready;
    logic [31:0]       m_axi_wdata;
    logic [3:0]        m_axi_wstrb;
    logic              m_axi_wvalid;
    logic              m_axi_wready;
    logic [1:0]        m_axi_bresp;
    logic              m_axi_bvalid;
    logic              m_axi_bready;
    logic [ADDR_W-1:0] m_axi_araddr;
    logic              m_axi_arvalid;
    logic              m_axi_arready;
    logic [31:0]       m_axi_rdata;
    logic [1:0]        m_axi_rresp;
    logic              m_axi_rvalid;
    logic              m_axi_rready;

    wb_axil_bridge #(
        .ADDR_W         (ADDR_W),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .wb_clk_i      (clk),
        .wb_rst_n_i    (rst_n),
        .wb_adr_i      (wb_adr_i),
        .wb_dat_i      (wb_dat_i),
        .wb_sel_i      (wb_sel_i),
        .wb_we_i       (wb_we_i),
        .wb_cyc_i      (wb_cyc_i),
        .wb_stb_i      (wb_stb_i),
        .wb_dat_o      (wb_dat_o),
        .wb_ack_o      (wb_ack_o),
        .wb_err_o      (wb_err_o),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready)
    );

    typedef struct {
        bit          we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [1:0]  resp;
        logic [31:0] rdata;
        int          aw_dly;
        int          w_dly;
        int          ar_dly;
        int          rsp_dly;
        bit          abort;
        int          exp_ack;
        int          exp_err;
        int          exp_lat;
        logic [31:0] exp_addr;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t vecs [NVEC];
    int   n_cmp;
    int   n_bad;
    int   wd_ack;
    int   wd_err;
    int   wd_errk;
    int   wd_dropk;
    int   wd_late;
    int   idle_bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_time_limit: simulation still running at %0t", $time);
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string p);
        chk({p, "_ctl"}, {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                          m_axi_rready, wb_ack_o, wb_err_o}, 64'd0);
        chk({p, "_awaddr"}, m_axi_awaddr, 64'd0);
        chk({p, "_wdata"}, m_axi_wdata, 64'd0);
        chk({p, "_wstrb"}, m_axi_wstrb, 64'd0);
        chk({p, "_araddr"}, m_axi_araddr, 64'd0);
        chk({p, "_dat_o"}, wb_dat_o, 64'd0);
    endtask

    task automatic slave_idle();
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        m_axi_arready = 1'b0;
        m_axi_bvalid  = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_bresp   = 2'b00;
        m_axi_rresp   = 2'b00;
        m_axi_rdata   = 32'h0;
    endtask

    // Drives one Wishbone request (cycle 0) and plays an AXI slave with the vector's delays.
    task automatic run_txn(input vec_t v, input int id);
        int          aw_cnt = 0;
        int          w_cnt = 0;
        int          ar_cnt = 0;
        int          since = 0;
        int          aw_hs = 0;
        int          w_hs = 0;
        int          ar_hs = 0;
        int          rsp_hk = -1;
        int          ack_n = 0;
        int          err_n = 0;
        int          first_k = -1;
        int          early = 0;
        bit          req_done;
        logic [31:0] dat_at = 32'h0;
        logic [31:0] cap_addr = 32'h0;
        logic [31:0] cap_wdata = 32'h0;
        logic [3:0]  cap_strb = 4'h0;
        wb_we_i  = v.we;
        wb_adr_i = v.adr;
        wb_dat_i = v.dat;
        wb_sel_i = v.sel;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        for (int k = 0; k < 100; k++) begin
            m_axi_awready = m_axi_awvalid && (aw_cnt >= v.aw_dly);
            if (m_axi_awvalid) aw_cnt++;
            m_axi_wready = m_axi_wvalid && (w_cnt >= v.w_dly);
            if (m_axi_wvalid) w_cnt++;
            m_axi_arready = m_axi_arvalid && (ar_cnt >= v.ar_dly);
            if (m_axi_arvalid) ar_cnt++;
            req_done     = v.we ? (aw_hs > 0 && w_hs > 0) : (ar_hs > 0);
            m_axi_bvalid = v.we && req_done && (rsp_hk < 0) && (since >= v.rsp_dly);
            m_axi_rvalid = !v.we && req_done && (rsp_hk < 0) && (since >= v.rsp_dly);
            m_axi_bresp  = v.resp;
            m_axi_rresp  = v.resp;
            m_axi_rdata  = v.rdata;
            if (m_axi_bready && !(aw_hs > 0 && w_hs > 0)) early++;
            if (m_axi_rready && ar_hs == 0) early++;
            if (m_axi_awvalid && m_axi_awready) begin
                aw_hs++;
                cap_addr = m_axi_awaddr;
            end
            if (m_axi_wvalid && m_axi_wready) begin
                w_hs++;
                cap_wdata = m_axi_wdata;
                cap_strb  = m_axi_wstrb;
            end
            if (m_axi_arvalid && m_axi_arready) begin
                ar_hs++;
                cap_addr = m_axi_araddr;
            end
            if ((m_axi_bvalid && m_axi_bready) || (m_axi_rvalid && m_axi_rready)) rsp_hk = k;
            if (req_done) since++;
            if (wb_ack_o || wb_err_o) begin
                if (first_k < 0) begin
                    first_k = k;
                    dat_at  = wb_dat_o;
                end
                if (wb_ack_o) ack_n++;
                if (wb_err_o) err_n++;
            end
            if (rsp_hk >= 0 && k >= rsp_hk + 4) break;
            tick();
            if (first_k >= 0 || v.abort) begin
                wb_cyc_i = 1'b0;
                wb_stb_i = 1'b0;
            end
        end
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        slave_idle();
        if (first_k < 0) dat_at = wb_dat_o;
        chk($sformatf("v%0d_resp_seen", id), (rsp_hk >= 0), 64'd1);
        chk($sformatf("v%0d_ack_count", id), ack_n, v.exp_ack);
        chk($sformatf("v%0d_err_count", id), err_n, v.exp_err);
        chk($sformatf("v%0d_latency", id), first_k, v.exp_lat);
        chk($sformatf("v%0d_dat_o", id), dat_at, v.exp_dat);
        chk($sformatf("v%0d_axaddr", id), cap_addr, v.exp_addr);
        chk($sformatf("v%0d_aw_hs", id), aw_hs, v.we ? 1 : 0);
        chk($sformatf("v%0d_w_hs", id), w_hs, v.we ? 1 : 0);
        chk($sformatf("v%0d_ar_hs", id), ar_hs, v.we ? 0 : 1);
        chk($sformatf("v%0d_ready_early", id), early, 64'd0);
        if (v.we) begin
            chk($sformatf("v%0d_wdata", id), cap_wdata, v.dat);
            chk($sformatf("v%0d_wstrb", id), cap_strb, v.sel);
        end
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        // we adr dat sel resp rdata | aw w ar rsp delays | abort | ack err lat | addr dat_o
        vecs[0]  = '{1'b1, 32'h1004, 32'hDEADBEEF, 4'hC, 2'b00, 32'h0, 0, 0, 0, 0, 1'b0,
                     1, 0, 4, 32'h1004, 32'h0};
        vecs[1]  = '{1'b1, 32'h1008, 32'h0BADF00D, 4'hF, 2'b00, 32'h0, 3, 0, 0, 0, 1'b0,
                     1, 0, 7, 32'h1008, 32'h0};
        vecs[2]  = '{1'b1, 32'h100C, 32'h11223344, 4'h1, 2'b00, 32'h0, 0, 3, 0, 0, 1'b0,
                     1, 0, 7, 32'h100C, 32'h0};
        vecs[3]  = '{1'b1, 32'h2003, 32'h55AA55AA, 4'h3, 2'b10, 32'h0, 0, 0, 0, 2, 1'b0,
                     0, 1, 6, 32'h2000, 32'h0};
        vecs[4]  = '{1'b0, 32'h2000, 32'h0, 4'hF, 2'b00, 32'h12345678, 0, 0, 0, 0, 1'b0,
                     1, 0, 4, 32'h2000, 32'h12345678};
        vecs[5]  = '{1'b0, 32'h3000, 32'h0, 4'hF, 2'b11, 32'hCAFEF00D, 0, 0, 0, 0, 1'b0,
                     0, 1, 4, 32'h3000, 32'hCAFEF00D};
        vecs[6]  = '{1'b1, 32'h1010, 32'hFFFFFFFF, 4'hF, 2'b01, 32'h0, 0, 0, 0, 0, 1'b0,
                     1, 0, 4, 32'h1010, 32'hCAFEF00D};
        vecs[7]  = '{1'b0, 32'h0040, 32'h0, 4'hF, 2'b01, 32'hA5A55A5A, 0, 0, 2, 1, 1'b0,
                     1, 0, 7, 32'h0040, 32'hA5A55A5A};
        vecs[8]  = '{1'b1, 32'h1020, 32'h99887766, 4'h6, 2'b00, 32'h0, 2, 1, 0, 0, 1'b1,
                     0, 0, -1, 32'h1020, 32'hA5A55A5A};
        vecs[9]  = '{1'b0, 32'h3004, 32'h0, 4'hF, 2'b11, 32'h01020304, 0, 0, 1, 0, 1'b1,
                     0, 0, -1, 32'h3004, 32'h01020304};
        vecs[10] = '{1'b0, 32'h0044, 32'h0, 4'hF, 2'b00, 32'h0F0F0F0F, 0, 0, 0, 0, 1'b0,
                     1, 0, 4, 32'h0044, 32'h0F0F0F0F};

        rst_n    = 1'b0;
        wb_adr_i = '0;
        wb_dat_i = '0;
        wb_sel_i = '0;
        wb_we_i  = 1'b0;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        slave_idle();
        #1;
        chk_all_zero("reset");
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();

        for (int i = 0; i < NVEC; i++) begin
            run_txn(vecs[i], i);
        end

        // Asynchronous reset while waiting in WRESP
        wb_we_i       = 1'b1;
        wb_adr_i      = 32'h1004;
        wb_dat_i      = 32'h12345678;
        wb_sel_i      = 4'hF;
        wb_cyc_i      = 1'b1;
        wb_stb_i      = 1'b1;
        m_axi_awready = 1'b1;
        m_axi_wready  = 1'b1;
        tick();
        chk("arst_pre_awvalid", m_axi_awvalid, 64'd1);
        chk("arst_pre_wvalid", m_axi_wvalid, 64'd1);
        tick();
        chk("arst_pre_bready", m_axi_bready, 64'd1);
        chk("arst_pre_awvalid_low", m_axi_awvalid, 64'd0);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("arst");
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        slave_idle();
        @(posedge clk);
        #3 rst_n = 1'b1;
        idle_bad = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (wb_ack_o || wb_err_o || m_axi_awvalid || m_axi_wvalid || m_axi_bready ||
                m_axi_arvalid || m_axi_rready) idle_bad++;
        end
        chk("arst_post_idle", idle_bad, 64'd0);
        run_txn(vecs[0], 100);

        // Response that never arrives
        wb_we_i       = 1'b1;
        wb_adr_i      = 32'h1100;
        wb_dat_i      = 32'hFEEDC0DE;
        wb_sel_i      = 4'hF;
        wb_cyc_i      = 1'b1;
        wb_stb_i      = 1'b1;
        m_axi_awready = 1'b1;
        m_axi_wready  = 1'b1;
        tick();
        tick();
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        chk("wd_bready_start", m_axi_bready, 64'd1);
        wd_ack   = 0;
        wd_err   = 0;
        wd_errk  = -1;
        wd_dropk = -1;
        wd_late  = 0;
`ifdef WB_AXIL_TIMEOUT_EN
        for (int k = 0; k < 40; k++) begin
            if (!m_axi_bready && wd_dropk < 0) wd_dropk = k;
            if (wd_dropk >= 0 && m_axi_bready) wd_late++;
            if (wb_ack_o) wd_ack++;
            if (wb_err_o) begin
                wd_err++;
                wd_errk = k;
            end
            if (wd_errk >= 0) begin
                m_axi_bvalid = 1'b1;
                wb_cyc_i     = 1'b0;
                wb_stb_i     = 1'b0;
            end
            tick();
        end
        chk("wd_ack_count", wd_ack, 64'd0);
        chk("wd_err_count", wd_err, 64'd1);
        chk("wd_drop_window", (wd_dropk >= TO_CYC - 2 && wd_dropk <= TO_CYC), 64'd1);
        chk("wd_err_window", (wd_errk >= TO_CYC - 1 && wd_errk <= TO_CYC + 1), 64'd1);
        chk("wd_bready_after_drop", wd_late, 64'd0);
`else
        for (int k = 0; k < 1000; k++) begin
            if (wb_ack_o) wd_ack++;
            if (wb_err_o) wd_err++;
            tick();
        end
        chk("nowd_ack_err", wd_ack + wd_err, 64'd0);
        chk("nowd_bready_held", m_axi_bready, 64'd1);
`endif
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        slave_idle();
        #2 rst_n = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        run_txn(vecs[4], 101);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
